mem_ctrl_mp: RTL and testbench
==============================

Name: mem_ctrl_mp

Overview:
- Parametrised, multi-port successor to the single-client memory controller.
- Arbitrates NUM_PORTS clients (e.g. instruction fetch and load/store) onto one memory interface using round-robin.
- Registers the request toward memory and holds the last read result.
- Adds per-port write acknowledge and a configurable response timeout with error reporting.

Parameters:
- NUM_PORTS, 2, number of client ports (>=1).
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 16, data width.
- TIMEOUT, 255, max cycles waiting for memory response; 0 disables timeout.

Ports:
- I_clk  in  1  clock, all logic on rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_exec  in  NUM_PORTS  per-port request strobe.
- I_write  in  NUM_PORTS  per-port request type: 1=write, 0=read.
- I_addr  in  NUM_PORTS*ADDR_WIDTH  port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- I_data  in  NUM_PORTS*DATA_WIDTH  write data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- O_data  out  DATA_WIDTH  last read data, shared by all ports, held until next read completes.
- O_data_ready  out  NUM_PORTS  one-cycle pulse: read complete for port i.
- O_ack  out  NUM_PORTS  one-cycle pulse: write complete for port i.
- O_error  out  NUM_PORTS  one-cycle pulse: timeout on port i's transaction.
- O_ready  out  NUM_PORTS  combinational: port i may issue.
- MEM_ready  in  1  memory idle/able to accept.
- MEM_exec  out  1  one-cycle request strobe to memory.
- MEM_write  out  1  latched request type.
- MEM_addr  out  ADDR_WIDTH  latched address.
- MEM_data_out  out  DATA_WIDTH  latched write data.
- MEM_data_in  in  DATA_WIDTH  read data from memory.
- MEM_data_ready  in  1  read data valid.

Behaviour:
- Reset (synchronous, I_reset=1 at edge):
  - State IDLE.
  - MEM_exec, MEM_write, MEM_addr, MEM_data_out, O_data = 0.
  - O_data_ready, O_ack, O_error = 0.
  - Round-robin pointer rr = 0; timeout counter = 0.
  - O_ready forced 0 while I_reset=1.
- O_ready[i] = !I_reset && state==IDLE && MEM_ready && !I_exec[i].
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, MEM_ready=1, any I_exec bit set:
  - Grant g = first set I_exec bit scanning rr, rr+1, ... modulo NUM_PORTS.
  - Latch I_addr/I_data/I_write slice g onto MEM_addr/MEM_data_out/MEM_write.
  - MEM_exec<=1; store g; rr<=(g+1) mod NUM_PORTS; clear timeout counter.
  - Next state RD_WAIT if write=0, else WR_WAIT.
- IDLE with MEM_ready=0: no grant; requests wait, no loss, rr unchanged.
- MEM_exec is high for exactly one cycle per grant; cleared in either wait state.
- MEM_addr/MEM_write/MEM_data_out hold stable from grant until the next grant.
- RD_WAIT:
  - MEM_data_ready=1 -> O_data<=MEM_data_in, O_data_ready[g]<=1 (one cycle), state IDLE.
  - Otherwise counter++.
- WR_WAIT:
  - Evaluated from the cycle after the grant.
  - MEM_ready=1 -> O_ack[g]<=1 (one cycle), state IDLE.
  - Otherwise counter++.
- Timeout (TIMEOUT>0): counter reaching TIMEOUT in a wait state -> O_error[g]<=1 (one cycle), state IDLE, no data/ack pulse, O_data unchanged.
- Counter width: clog2(TIMEOUT+1), minimum 1; saturates, never wraps.
- Simultaneous completion and timeout on the same edge: completion wins, no error pulse.
- Pulses and grants: all pulses are registered. A new grant is possible on the edge after returning to IDLE. Minimum read turnaround is 2 edges.
- Reset mid-transaction: immediate IDLE, transaction dropped, no pulse emitted, MEM_exec=0.
- Only one transaction is outstanding at a time; no pipelining.
- NUM_PORTS=1 degenerates to a single-client controller; rr stays 0.

Test Plan:
- Read port 0: MEM_ready=1, I_exec=2'b01, addr 16'h0040; MEM_data_ready=1 with 16'hBEEF three cycles later -> MEM_exec one-cycle pulse, MEM_addr=16'h0040, then O_data=16'hBEEF, O_data_ready=2'b01 for one cycle, O_ready returns high.
- Write port 1: I_exec=2'b10, I_write=2'b10, addr 16'h0100, data 16'h1234; MEM_ready low 2 cycles then high -> MEM_write=1, MEM_data_out=16'h1234, O_ack=2'b10 single pulse, O_data unchanged.
- Round-robin: I_exec=2'b11 held, instant responses -> grants alternate 0,1,0,1 over 4 transactions; no starvation.
- Timeout: TIMEOUT=4, read with MEM_data_ready never asserted -> O_error[g] pulses 4 cycles after entering RD_WAIT, state IDLE, O_data_ready stays 0.
- Reset mid-read: I_reset=1 while in RD_WAIT -> next cycle all outputs 0, later MEM_data_ready produces no O_data_ready pulse.
- Backpressure: MEM_ready=0 with I_exec=2'b01 for 5 cycles -> no MEM_exec, O_ready=0; grant occurs on the first edge after MEM_ready=1.

Source files
------------

// File: rtl/mem_ctrl_mp.sv
// rtl/mem_ctrl_mp.sv - round-robin multi-port memory controller with write ack and response timeout
//
// Arbitrates NUM_PORTS clients onto one memory interface, one transaction
// outstanding at a time. The winning request is registered toward memory and
// the last read result is held on O_data.
//
// Ports:
//   I_clk, I_reset          clock, synchronous active-high reset
//   I_exec/I_write          per-port request strobe and type (1=write)
//   I_addr/I_data           packed per-port address and write data
//   O_data                  last read data, shared by all ports
//   O_data_ready/O_ack      per-port one-cycle read-done / write-done pulses
//   O_error                 per-port one-cycle timeout pulse
//   O_ready                 per-port combinational "may issue"
//   MEM_*                   memory-side request and response signals
module mem_ctrl_mp #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                            I_clk,
  input  logic                            I_reset,
  input  logic [NUM_PORTS-1:0]            I_exec,
  input  logic [NUM_PORTS-1:0]            I_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] I_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] I_data,
  output logic [DATA_WIDTH-1:0]           O_data,
  output logic [NUM_PORTS-1:0]            O_data_ready,
  output logic [NUM_PORTS-1:0]            O_ack,
  output logic [NUM_PORTS-1:0]            O_error,
  output logic [NUM_PORTS-1:0]            O_ready,
  input  logic                            MEM_ready,
  output logic                            MEM_exec,
  output logic                            MEM_write,
  output logic [ADDR_WIDTH-1:0]           MEM_addr,
  output logic [DATA_WIDTH-1:0]           MEM_data_out,
  input  logic [DATA_WIDTH-1:0]           MEM_data_in,
  input  logic                            MEM_data_ready
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT} state_t;

  state_t                r_state, w_state_next;
  logic [PW-1:0]         r_rr, r_gnt, w_gnt, w_rr_next;
  logic [CW-1:0]         r_cnt, w_cnt_inc;
  logic                  r_mem_exec, r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data, r_o_data;
  logic [NUM_PORTS-1:0]  r_data_ready, r_ack, r_error;
  logic [NUM_PORTS-1:0]  w_gnt_oh, w_cur_oh;
  logic [2*NUM_PORTS-1:0] w_rot;
  logic                  w_found, w_gnt_write, w_tmo_hit;
  logic                  w_grant, w_rd_done, w_wr_done, w_tmo;
  int                    w_sum;

  // Rotating the doubled request vector by rr lets a plain lowest-bit scan
  // implement the round-robin priority order rr, rr+1, ...
  always_comb begin
    w_rot   = {I_exec, I_exec} >> r_rr;
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = int'(r_rr) + k;
        if (w_sum >= NUM_PORTS) w_sum = w_sum - NUM_PORTS;
        w_gnt   = PW'(w_sum);
      end
    end
    w_sum = int'(w_gnt) + 1;
    if (w_sum >= NUM_PORTS) w_sum = 0;
    w_rr_next = PW'(w_sum);
  end

  assign w_gnt_oh    = NUM_PORTS'(1) << w_gnt;
  assign w_cur_oh    = NUM_PORTS'(1) << r_gnt;
  assign w_gnt_write = |(I_write & w_gnt_oh);

  // Saturating increment; the timeout fires on the edge the count would
  // reach TIMEOUT.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_tmo_hit = (TIMEOUT > 0) && (w_cnt_inc == CNT_LIMIT);

  always_ff @(posedge I_clk) begin
    if (I_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_rd_done    = 1'b0;
    w_wr_done    = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MEM_ready && w_found) begin
          w_grant      = 1'b1;
          w_state_next = w_gnt_write ? S_WR_WAIT : S_RD_WAIT;
        end
      end
      // Completion is checked before timeout so a same-edge tie completes.
      S_RD_WAIT: begin
        if (MEM_data_ready) begin
          w_rd_done    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (MEM_ready) begin
          w_wr_done    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_tmo        = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_rr         <= '0;
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_mem_exec   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_o_data     <= '0;
      r_data_ready <= '0;
      r_ack        <= '0;
      r_error      <= '0;
    end else begin
      r_mem_exec   <= w_grant;
      r_data_ready <= '0;
      r_ack        <= '0;
      r_error      <= '0;
      if (w_grant) begin
        r_mem_write <= w_gnt_write;
        r_mem_addr  <= ADDR_WIDTH'(I_addr >> (int'(w_gnt) * ADDR_WIDTH));
        r_mem_data  <= DATA_WIDTH'(I_data >> (int'(w_gnt) * DATA_WIDTH));
        r_gnt       <= w_gnt;
        r_rr        <= w_rr_next;
        r_cnt       <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_rd_done) begin
        r_o_data     <= MEM_data_in;
        r_data_ready <= w_cur_oh;
      end
      if (w_wr_done) r_ack   <= w_cur_oh;
      if (w_tmo)     r_error <= w_cur_oh;
    end
  end

  assign O_ready      = (!I_reset && r_state == S_IDLE && MEM_ready) ? ~I_exec : '0;
  assign O_data       = r_o_data;
  assign O_data_ready = r_data_ready;
  assign O_ack        = r_ack;
  assign O_error      = r_error;
  assign MEM_exec     = r_mem_exec;
  assign MEM_write    = r_mem_write;
  assign MEM_addr     = r_mem_addr;
  assign MEM_data_out = r_mem_data;

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// tb/tb_mem_ctrl_mp.sv - cycle-vector bench for mem_ctrl_mp (2 ports, TIMEOUT=4)
module tb_mem_ctrl_mp;

  logic        I_clk;
  logic        I_reset;
  logic [1:0]  I_exec, I_write;
  logic [31:0] I_addr, I_data;
  logic [15:0] O_data;
  logic [1:0]  O_data_ready, O_ack, O_error, O_ready;
  logic        MEM_ready, MEM_exec, MEM_write, MEM_data_ready;
  logic [15:0] MEM_addr, MEM_data_out, MEM_data_in;

  mem_ctrl_mp #(
    .NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)
  ) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_exec(I_exec), .I_write(I_write),
    .I_addr(I_addr), .I_data(I_data), .O_data(O_data),
    .O_data_ready(O_data_ready), .O_ack(O_ack), .O_error(O_error),
    .O_ready(O_ready), .MEM_ready(MEM_ready), .MEM_exec(MEM_exec),
    .MEM_write(MEM_write), .MEM_addr(MEM_addr), .MEM_data_out(MEM_data_out),
    .MEM_data_in(MEM_data_in), .MEM_data_ready(MEM_data_ready)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct packed {
    logic        rst;
    logic [1:0]  exec;
    logic [1:0]  wr;
    logic        mrdy;
    logic        mdrdy;
    logic [15:0] mdin;
    logic        x_mexec;
    logic        x_mwr;
    logic [15:0] x_maddr;
    logic [15:0] x_mdout;
    logic [15:0] x_odata;
    logic [1:0]  x_odrdy;
    logic [1:0]  x_oack;
    logic [1:0]  x_oerr;
    logic [1:0]  x_ordy;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(
    input logic rst, input logic [1:0] exec, input logic [1:0] wr,
    input logic mrdy, input logic mdrdy, input logic [15:0] mdin,
    input logic mexec, input logic mwr, input logic [15:0] maddr,
    input logic [15:0] mdout, input logic [15:0] odata, input logic [1:0] odrdy,
    input logic [1:0] oack, input logic [1:0] oerr, input logic [1:0] ordy);
    vec_t v;
    v = '{rst, exec, wr, mrdy, mdrdy, mdin, mexec, mwr, maddr, mdout,
          odata, odrdy, oack, oerr, ordy};
    return v;
  endfunction

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic apply(input vec_t v, input string nm);
    I_reset        = v.rst;
    I_exec         = v.exec;
    I_write        = v.wr;
    MEM_ready      = v.mrdy;
    MEM_data_ready = v.mdrdy;
    MEM_data_in    = v.mdin;
    @(posedge I_clk);
    #1;
    n_vec++;
    if ({MEM_exec, MEM_write, MEM_addr, MEM_data_out, O_data, O_data_ready, O_ack, O_error, O_ready} !==
        {v.x_mexec, v.x_mwr, v.x_maddr, v.x_mdout, v.x_odata, v.x_odrdy, v.x_oack, v.x_oerr, v.x_ordy}) begin
      n_err++;
      $display("FAIL %s: got exec=%b wr=%b addr=%h dout=%h data=%h drdy=%b ack=%b err=%b rdy=%b; want exec=%b wr=%b addr=%h dout=%h data=%h drdy=%b ack=%b err=%b rdy=%b",
               nm, MEM_exec, MEM_write, MEM_addr, MEM_data_out, O_data, O_data_ready, O_ack, O_error, O_ready,
               v.x_mexec, v.x_mwr, v.x_maddr, v.x_mdout, v.x_odata, v.x_odrdy, v.x_oack, v.x_oerr, v.x_ordy);
    end
  endtask

  vec_t tbl[28];

  initial begin
    I_addr = {16'h0100, 16'h0040};
    I_data = {16'h1234, 16'h5678};
    I_reset = 1'b1; I_exec = '0; I_write = '0;
    MEM_ready = 1'b1; MEM_data_ready = 1'b0; MEM_data_in = '0;

    // reset, idle
    tbl[0]  = mk(1, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b11);
    // read port 0, data on third edge after grant
    tbl[2]  = mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, 0, 16'h0040, 16'h5678, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[3]  = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[4]  = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[5]  = mk(0, 2'b00, 2'b00, 1, 1, 16'hBEEF, 0, 0, 16'h0040, 16'h5678, 16'hBEEF, 2'b01, 2'b00, 2'b00, 2'b11);
    tbl[6]  = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b11);
    // write port 1, memory busy two cycles
    tbl[7]  = mk(0, 2'b10, 2'b10, 1, 0, 16'h0000, 1, 1, 16'h0100, 16'h1234, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[8]  = mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[9]  = mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[10] = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'hBEEF, 2'b00, 2'b10, 2'b00, 2'b11);
    tbl[11] = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b11);
    // round-robin with both ports requesting, instant responses
    tbl[12] = mk(0, 2'b11, 2'b00, 1, 1, 16'h1111, 1, 0, 16'h0040, 16'h5678, 16'hBEEF, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[13] = mk(0, 2'b11, 2'b00, 1, 1, 16'h1111, 0, 0, 16'h0040, 16'h5678, 16'h1111, 2'b01, 2'b00, 2'b00, 2'b00);
    tbl[14] = mk(0, 2'b11, 2'b00, 1, 1, 16'h2222, 1, 0, 16'h0100, 16'h1234, 16'h1111, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[15] = mk(0, 2'b11, 2'b00, 1, 1, 16'h2222, 0, 0, 16'h0100, 16'h1234, 16'h2222, 2'b10, 2'b00, 2'b00, 2'b00);
    tbl[16] = mk(0, 2'b11, 2'b00, 1, 1, 16'h3333, 1, 0, 16'h0040, 16'h5678, 16'h2222, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[17] = mk(0, 2'b11, 2'b00, 1, 1, 16'h3333, 0, 0, 16'h0040, 16'h5678, 16'h3333, 2'b01, 2'b00, 2'b00, 2'b00);
    tbl[18] = mk(0, 2'b11, 2'b00, 1, 1, 16'h4444, 1, 0, 16'h0100, 16'h1234, 16'h3333, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[19] = mk(0, 2'b11, 2'b00, 1, 1, 16'h4444, 0, 0, 16'h0100, 16'h1234, 16'h4444, 2'b10, 2'b00, 2'b00, 2'b00);
    // backpressure: five cycles of MEM_ready=0, then grant
    for (int i = 20; i < 25; i++)
      tbl[i] = mk(0, 2'b01, 2'b00, 0, 0, 16'h0000, 0, 0, 16'h0100, 16'h1234, 16'h4444, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[25] = mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, 0, 16'h0040, 16'h5678, 16'h4444, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[26] = mk(0, 2'b00, 2'b00, 1, 1, 16'h5555, 0, 0, 16'h0040, 16'h5678, 16'h5555, 2'b01, 2'b00, 2'b00, 2'b11);
    tbl[27] = mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'h5555, 2'b00, 2'b00, 2'b00, 2'b11);

    for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // read timeout on port 1: error on the 4th edge in RD_WAIT
    apply(mk(0, 2'b10, 2'b00, 1, 0, 16'h0000, 1, 0, 16'h0100, 16'h1234, 16'h5555, 2'b00, 2'b00, 2'b00, 2'b00), "rd_tmo grant");
    for (int i = 1; i < 4; i++)
      apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0100, 16'h1234, 16'h5555, 2'b00, 2'b00, 2'b00, 2'b00), $sformatf("rd_tmo wait%0d", i));
    apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0100, 16'h1234, 16'h5555, 2'b00, 2'b00, 2'b10, 2'b11), "rd_tmo error");
    apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0100, 16'h1234, 16'h5555, 2'b00, 2'b00, 2'b00, 2'b11), "rd_tmo after");

    // data arrives on the same edge the timeout would fire: completion wins
    apply(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, 0, 16'h0040, 16'h5678, 16'h5555, 2'b00, 2'b00, 2'b00, 2'b00), "tie grant");
    for (int i = 1; i < 4; i++)
      apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'h5555, 2'b00, 2'b00, 2'b00, 2'b00), $sformatf("tie wait%0d", i));
    apply(mk(0, 2'b00, 2'b00, 1, 1, 16'h6666, 0, 0, 16'h0040, 16'h5678, 16'h6666, 2'b01, 2'b00, 2'b00, 2'b11), "tie done");
    apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'h6666, 2'b00, 2'b00, 2'b00, 2'b11), "tie after");

    // write timeout on port 1, no late ack once memory frees up
    apply(mk(0, 2'b10, 2'b10, 1, 0, 16'h0000, 1, 1, 16'h0100, 16'h1234, 16'h6666, 2'b00, 2'b00, 2'b00, 2'b00), "wr_tmo grant");
    for (int i = 1; i < 4; i++)
      apply(mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'h6666, 2'b00, 2'b00, 2'b00, 2'b00), $sformatf("wr_tmo wait%0d", i));
    apply(mk(0, 2'b00, 2'b00, 0, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'h6666, 2'b00, 2'b00, 2'b10, 2'b00), "wr_tmo error");
    apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 16'h6666, 2'b00, 2'b00, 2'b00, 2'b11), "wr_tmo after");

    // reset during RD_WAIT drops the read; rr returns to 0
    apply(mk(0, 2'b01, 2'b00, 1, 0, 16'h0000, 1, 0, 16'h0040, 16'h5678, 16'h6666, 2'b00, 2'b00, 2'b00, 2'b00), "rst grant");
    apply(mk(0, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0040, 16'h5678, 16'h6666, 2'b00, 2'b00, 2'b00, 2'b00), "rst wait");
    apply(mk(1, 2'b00, 2'b00, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00), "rst assert");
    apply(mk(0, 2'b00, 2'b00, 1, 1, 16'h7777, 0, 0, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b11), "rst late data");
    apply(mk(0, 2'b11, 2'b00, 1, 0, 16'h0000, 1, 0, 16'h0040, 16'h5678, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00), "rst rr grant");
    apply(mk(0, 2'b00, 2'b00, 1, 1, 16'h8888, 0, 0, 16'h0040, 16'h5678, 16'h8888, 2'b01, 2'b00, 2'b00, 2'b11), "rst rr done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
